// File: rtl/mb8_arb.sv
// Round-robin arbiter sharing one 8-bit SPRAM bus between N requesters.
// A 16-bit cell access is split into two big-endian byte cycles.
module mb8_arb #(
  parameter int N   = 2,
  parameter int ASZ = 17,
  parameter int DSZ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     we,
  input  logic [N-1:0]     w16,
  input  logic [N*ASZ-1:0] addr,
  input  logic [N*16-1:0]  wdata,
  output logic [N-1:0]     ack,
  output logic [15:0]      rdata,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             mem_we,
  output logic [ASZ-1:0]   mem_ai,
  output logic [DSZ-1:0]   mem_vi,
  input  logic [DSZ-1:0]   mem_vo
);

  typedef enum logic [1:0] {IDLE, B0, B1, DONE} state_t;

  state_t         state, state_nx;
  logic [1:0]     last, win;
  logic           found;
  logic [3:0]     req4, we4, w164;
  logic [N-1:0]   gnt_oh;
  logic [ASZ-1:0] addr_l, addr_sel;
  logic [15:0]    wdata_sel, rdata_q;
  logic [7:0]     wlo_l, hi_l;
  logic           we_l, w16_l;

  assign req4      = 4'(req);
  assign we4       = 4'(we);
  assign w164      = 4'(w16);
  assign addr_sel  = addr[int'(win)*ASZ +: ASZ];
  assign wdata_sel = wdata[int'(win)*16 +: 16];

  // Winner is the first requester found searching cyclically from last+1.
  always_comb begin : pick
    int j;
    found = 1'b0;
    win   = last;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last) + k;
      if (j >= N) j = j - N;
      if (!found && req4[2'(j)]) begin
        found = 1'b1;
        win   = 2'(j);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N; i++) gnt_oh[i] = (gnt_id == 2'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = B0;
      B0:      state_nx = w16_l ? B1 : DONE;
      B1:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are loaded on the edge entering the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack     <= '0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      mem_ai  <= '0;
      mem_vi  <= '0;
      rdata_q <= '0;
      gnt_id  <= 2'd0;
      last    <= 2'(N-1);
      addr_l  <= '0;
      wlo_l   <= '0;
      hi_l    <= '0;
      we_l    <= 1'b0;
      w16_l   <= 1'b0;
    end else begin
      ack  <= '0;
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (found) begin
            we_l   <= we4[win];
            w16_l  <= w164[win];
            addr_l <= addr_sel;
            wlo_l  <= wdata_sel[7:0];
            gnt_id <= win;
            last   <= win;
            mem_ai <= addr_sel;
            mem_vi <= w164[win] ? wdata_sel[15:8] : wdata_sel[7:0];
            mem_we <= we4[win];
          end
        end
        B0: begin
          if (w16_l) begin
            mem_ai <= addr_l + ASZ'(1);
            mem_vi <= wlo_l;
            mem_we <= we_l;
          end else begin
            mem_we <= 1'b0;
            ack    <= gnt_oh;
          end
        end
        B1: begin
          hi_l   <= mem_vo;
          mem_we <= 1'b0;
          ack    <= gnt_oh;
        end
        DONE: begin
          if (!we_l) rdata_q <= rdata;
        end
        default: ;
      endcase
    end
  end

  // The memory read is registered, so the last byte only arrives during DONE;
  // it is forwarded straight to rdata there and held in rdata_q afterwards.
  assign rdata = (state == DONE && !we_l) ? (w16_l ? {hi_l, mem_vo} : {8'h00, mem_vo})
                                          : rdata_q;

endmodule

// File: tb/tb_mb8_arb.sv
// Self-checking bench for mb8_arb with a registered-read 128K byte memory model.
// Expected acks are queued when a request is driven and popped when ack appears.
module tb_mb8_arb;
  localparam int N   = 2;
  localparam int ASZ = 17;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] rd;
    bit          chk_rd;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req, we, w16;
  logic [16:0]    a0, a1;
  logic [15:0]    d0, d1;
  logic [N-1:0]   ack;
  logic [15:0]    rdata;
  logic [1:0]     gnt_id;
  logic           busy, mem_we;
  logic [ASZ-1:0] mem_ai;
  logic [7:0]     mem_vi, mem_vo;

  logic [7:0]  mem [0:(1<<ASZ)-1];
  logic        bd_we = 1'b0;
  logic [16:0] bd_a  = '0;
  logic [7:0]  bd_d  = '0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        sb[$];
  logic [16:0] ai_log[$];
  logic [24:0] w_log[$];

  mb8_arb #(.N(N), .ASZ(ASZ), .DSZ(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .w16(w16),
    .addr({a1, a0}), .wdata({d1, d0}),
    .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
    .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_we) mem[mem_ai] <= mem_vi;
    mem_vo <= mem[mem_ai];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Observation only: logs bus activity until an ack appears or the budget runs out.
  task automatic wait_ack(output int cyc, output bit tmo);
    cyc = 0; tmo = 1'b1;
    ai_log.delete(); w_log.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_we) w_log.push_back({mem_ai, mem_vi});
      if (ack != '0) begin tmo = 1'b0; break; end
      if (busy) ai_log.push_back(mem_ai);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req = '0; we = '0; w16 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_ack got %h want 0", ack); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mem_ai !== 17'h0) begin n_bad++; $display("[TB] FAIL reset_mem_ai got %h want 0", mem_ai); end
    n_cmp++; if (mem_vi !== 8'h0) begin n_bad++; $display("[TB] FAIL reset_mem_vi got %h want 0", mem_vi); end
    n_cmp++; if (rdata !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if (gnt_id !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_gnt_id got %0d want 0", gnt_id); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    exp_t e; int cyc; bit tmo;
    req = 2'b01; we = 2'b01; w16 = 2'b00; a0 = 17'h00010; d0 = 16'h00A5;
    sb.push_back('{id: 2'd0, rd: 16'h0, chk_rd: 1'b0, lat: 2});
    wait_ack(cyc, tmo);
    req = '0;
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL wr_timeout no ack within budget"); end
    n_cmp++; if (cyc != e.lat) begin n_bad++; $display("[TB] FAIL wr_latency got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (ack !== 2'(1) << e.id) begin n_bad++; $display("[TB] FAIL wr_ack got %b want %b", ack, 2'(1) << e.id); end
    n_cmp++; if (gnt_id !== e.id) begin n_bad++; $display("[TB] FAIL wr_gnt_id got %0d want %0d", gnt_id, e.id); end
    n_cmp++; if (w_log.size() != 1) begin n_bad++; $display("[TB] FAIL wr_count got %0d want 1", w_log.size()); end
    if (w_log.size() == 1) begin
      n_cmp++; if (w_log[0] !== {17'h00010, 8'hA5}) begin n_bad++; $display("[TB] FAIL wr_bus got %h want %h", w_log[0], {17'h00010, 8'hA5}); end
    end
    n_cmp++; if (mem[17'h00010] !== 8'hA5) begin n_bad++; $display("[TB] FAIL wr_mem got %h want a5", mem[17'h00010]); end
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("[TB] FAIL wr_ack_pulse got %b want 00", ack); end
  endtask

  task automatic test_w16_read;
    exp_t e; int cyc; bit tmo;
    preload(17'h00100, 8'h12);
    preload(17'h00101, 8'h34);
    req = 2'b10; we = 2'b00; w16 = 2'b10; a1 = 17'h00100;
    sb.push_back('{id: 2'd1, rd: 16'h1234, chk_rd: 1'b1, lat: 3});
    wait_ack(cyc, tmo);
    req = '0;
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL rd16_timeout no ack within budget"); end
    n_cmp++; if (cyc != e.lat) begin n_bad++; $display("[TB] FAIL rd16_latency got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (ack !== 2'(1) << e.id) begin n_bad++; $display("[TB] FAIL rd16_ack got %b want %b", ack, 2'(1) << e.id); end
    n_cmp++; if (gnt_id !== e.id) begin n_bad++; $display("[TB] FAIL rd16_gnt_id got %0d want %0d", gnt_id, e.id); end
    n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL rd16_rdata got %h want %h", rdata, e.rd); end
    n_cmp++; if (ai_log.size() != 2) begin n_bad++; $display("[TB] FAIL rd16_ai_count got %0d want 2", ai_log.size()); end
    if (ai_log.size() == 2) begin
      n_cmp++; if (ai_log[0] !== 17'h00100) begin n_bad++; $display("[TB] FAIL rd16_ai0 got %h want 00100", ai_log[0]); end
      n_cmp++; if (ai_log[1] !== 17'h00101) begin n_bad++; $display("[TB] FAIL rd16_ai1 got %h want 00101", ai_log[1]); end
    end
    n_cmp++; if (w_log.size() != 0) begin n_bad++; $display("[TB] FAIL rd16_no_write got %0d want 0", w_log.size()); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL rd16_hold got %h want %h", rdata, e.rd); end
  endtask

  task automatic test_contention;
    exp_t e; int cyc; bit tmo;
    preload(17'h00200, 8'h11);
    preload(17'h00300, 8'h22);
    req = 2'b11; we = 2'b00; w16 = 2'b00; a0 = 17'h00200; a1 = 17'h00300;
    sb.push_back('{id: 2'd0, rd: 16'h0011, chk_rd: 1'b1, lat: 2});
    sb.push_back('{id: 2'd1, rd: 16'h0022, chk_rd: 1'b1, lat: 3});
    sb.push_back('{id: 2'd0, rd: 16'h0011, chk_rd: 1'b1, lat: 3});
    sb.push_back('{id: 2'd1, rd: 16'h0022, chk_rd: 1'b1, lat: 3});
    for (int t = 0; t < 4; t++) begin
      wait_ack(cyc, tmo);
      if (t == 3) req = '0;
      e = sb.pop_front();
      n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL rr%0d_timeout no ack within budget", t); end
      n_cmp++; if (ack !== 2'(1) << e.id) begin n_bad++; $display("[TB] FAIL rr%0d_ack got %b want %b", t, ack, 2'(1) << e.id); end
      n_cmp++; if (gnt_id !== e.id) begin n_bad++; $display("[TB] FAIL rr%0d_gnt_id got %0d want %0d", t, gnt_id, e.id); end
      n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL rr%0d_rdata got %h want %h", t, rdata, e.rd); end
      n_cmp++; if (cyc != e.lat) begin n_bad++; $display("[TB] FAIL rr%0d_latency got %0d want %0d", t, cyc, e.lat); end
    end
  endtask

  task automatic test_wrap;
    exp_t e; int cyc; bit tmo;
    req = 2'b01; we = 2'b01; w16 = 2'b01; a0 = 17'h1FFFF; d0 = 16'hBEEF;
    sb.push_back('{id: 2'd0, rd: 16'h0022, chk_rd: 1'b1, lat: 3});
    wait_ack(cyc, tmo);
    req = '0;
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL wrap_timeout no ack within budget"); end
    n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL wrap_rdata_kept got %h want %h", rdata, e.rd); end
    n_cmp++; if (w_log.size() != 2) begin n_bad++; $display("[TB] FAIL wrap_write_count got %0d want 2", w_log.size()); end
    if (w_log.size() == 2) begin
      n_cmp++; if (w_log[0] !== {17'h1FFFF, 8'hBE}) begin n_bad++; $display("[TB] FAIL wrap_w0 got %h want %h", w_log[0], {17'h1FFFF, 8'hBE}); end
      n_cmp++; if (w_log[1] !== {17'h00000, 8'hEF}) begin n_bad++; $display("[TB] FAIL wrap_w1 got %h want %h", w_log[1], {17'h00000, 8'hEF}); end
    end
    @(negedge clk);
    req = 2'b01; we = 2'b00; w16 = 2'b01; a0 = 17'h1FFFF;
    sb.push_back('{id: 2'd0, rd: 16'hBEEF, chk_rd: 1'b1, lat: 3});
    wait_ack(cyc, tmo);
    req = '0;
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL wrap_rb_timeout no ack within budget"); end
    n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL wrap_readback got %h want %h", rdata, e.rd); end
  endtask

  task automatic test_latch;
    exp_t e; int cyc; bit tmo;
    preload(17'h00050, 8'h7F);
    preload(17'h00060, 8'h99);
    req = 2'b01; we = 2'b00; w16 = 2'b00; a0 = 17'h00050;
    sb.push_back('{id: 2'd0, rd: 16'h007F, chk_rd: 1'b1, lat: 2});
    @(negedge clk);
    n_cmp++; if (mem_ai !== 17'h00050) begin n_bad++; $display("[TB] FAIL latch_ai_b0 got %h want 00050", mem_ai); end
    a0 = 17'h00060; req = '0;
    wait_ack(cyc, tmo);
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL latch_timeout no ack within budget"); end
    n_cmp++; if (cyc + 1 != e.lat) begin n_bad++; $display("[TB] FAIL latch_latency got %0d want %0d", cyc + 1, e.lat); end
    n_cmp++; if (ack !== 2'(1) << e.id) begin n_bad++; $display("[TB] FAIL latch_ack got %b want %b", ack, 2'(1) << e.id); end
    n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL latch_rdata got %h want %h", rdata, e.rd); end
    n_cmp++; if (mem_ai !== 17'h00050) begin n_bad++; $display("[TB] FAIL latch_ai_done got %h want 00050", mem_ai); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL latch_no_regrant got %b want 0", busy); end
  endtask

  task automatic test_reset_midop;
    exp_t e; int cyc; bit tmo;
    req = 2'b01; we = 2'b01; w16 = 2'b01; a0 = 17'h00400; d0 = 16'hCAFE;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_ai !== 17'h00401) begin n_bad++; $display("[TB] FAIL mid_b1 got we=%b ai=%h want we=1 ai=00401", mem_we, mem_ai); end
    rst = 1'b0; req = '0;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_mem_we got %b want 0", mem_we); end
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("[TB] FAIL mid_ack got %b want 00", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (gnt_id !== 2'd0 || rdata !== 16'h0) begin n_bad++; $display("[TB] FAIL mid_regs got gnt=%0d rdata=%h want 0/0000", gnt_id, rdata); end
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("[TB] FAIL mid_ack2 got %b want 00", ack); end
    rst = 1'b1;
    req = 2'b11; we = 2'b00; w16 = 2'b00; a0 = 17'h00050; a1 = 17'h00300;
    sb.push_back('{id: 2'd0, rd: 16'h007F, chk_rd: 1'b1, lat: 2});
    wait_ack(cyc, tmo);
    req = '0;
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_bad++; $display("[TB] FAIL mid_rel_timeout no ack within budget"); end
    n_cmp++; if (ack !== 2'(1) << e.id) begin n_bad++; $display("[TB] FAIL mid_first_ack got %b want %b", ack, 2'(1) << e.id); end
    n_cmp++; if (gnt_id !== e.id) begin n_bad++; $display("[TB] FAIL mid_first_gnt got %0d want %0d", gnt_id, e.id); end
    n_cmp++; if (rdata !== e.rd) begin n_bad++; $display("[TB] FAIL mid_first_rdata got %h want %h", rdata, e.rd); end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_write();
    test_w16_read();
    test_contention();
    test_wrap();
    test_latch();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
